ascii_hex_parser: RTL and testbench



---
 rtl/ascii_hex_parser.sv | 130 +++++++++++++
 tb/tb_ascii_hex_parser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: assembles ASCII hex digit strings into a binary word.
// One token per terminator (CR, LF, space); flags illegal characters and
// tokens longer than WORD_NIBBLES digits.
// Optional feature: define ASCII_HEX_LOWER_EN to accept 'a'-'f' as digits.
module ascii_hex_parser #(
    parameter int unsigned WORD_NIBBLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                char_in,
    input  logic                      char_vld,
    output logic [4*WORD_NIBBLES-1:0] value,
    output logic                      value_vld,
    output logic [3:0]                digits,
    output logic                      err_char,
    output logic                      err_ovf,
    output logic                      busy
);

    localparam int unsigned W = 4 * WORD_NIBBLES;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_t;

    state_t       state;
    logic [W-1:0] acc;
    logic [3:0]   count;

    logic         is_digit;
    logic         is_term;
    logic [3:0]   nib;

    // Classify the incoming character and decode its nibble value
    always_comb begin
        is_digit = 1'b0;
        is_term  = 1'b0;
        nib      = '0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_digit = 1'b1;
            nib      = 4'(char_in - 8'h30);
        end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
            is_digit = 1'b1;
            nib      = 4'(char_in - 8'h37);
        end
`ifdef ASCII_HEX_LOWER_EN
        else if (char_in >= 8'h61 && char_in <= 8'h66) begin
            is_digit = 1'b1;
            nib      = 4'(char_in - 8'h57);
        end
`endif
        else if (char_in == 8'h0D || char_in == 8'h0A || char_in == 8'h20) begin
            is_term = 1'b1;
        end
    end

    // Token FSM with registered outputs; pulses last exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            value     <= '0;
            value_vld <= 1'b0;
            digits    <= '0;
            err_char  <= 1'b0;
            err_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            value_vld <= 1'b0;
            err_char  <= 1'b0;
            err_ovf   <= 1'b0;
            if (char_vld) begin
                case (state)
                    IDLE: begin
                        if (is_digit) begin
                            acc   <= W'(nib);
                            count <= 4'd1;
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end else if (!is_term) begin
                            err_char <= 1'b1;
                            state    <= FLUSH;
                            busy     <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (is_digit) begin
                            if (count < 4'(WORD_NIBBLES)) begin
                                acc   <= (acc << 4) | W'(nib);
                                count <= count + 4'd1;
                            end else begin
                                err_ovf <= 1'b1;
                                state   <= FLUSH;
                            end
                        end else if (is_term) begin
                            value     <= acc;
                            digits    <= count;
                            value_vld <= 1'b1;
                            acc       <= '0;
                            count     <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            err_char <= 1'b1;
                            state    <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (is_term) begin
                            acc   <= '0;
                            count <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        acc   <= '0;
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Scoreboard bench for ascii_hex_parser: the stimulus pushes expected output
// events, a negedge monitor pops and compares whenever a pulse appears.
module tb_ascii_hex_parser;

    localparam int unsigned NIB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      char_in = '0;
    logic            char_vld = 1'b0;
    logic [4*NIB-1:0] value;
    logic            value_vld;
    logic [3:0]      digits;
    logic            err_char;
    logic            err_ovf;
    logic            busy;

    ascii_hex_parser #(.WORD_NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .char_in   (char_in),
        .char_vld  (char_vld),
        .value     (value),
        .value_vld (value_vld),
        .digits    (digits),
        .err_char  (err_char),
        .err_ovf   (err_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // kind encoding: {value_vld, err_char, err_ovf}
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] val;
        logic [3:0]  dig;
    } ev_t;

    ev_t         sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_value  = '0;
    logic [3:0]  exp_digits = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_val(input logic [31:0] v, input logic [3:0] d);
        ev_t e;
        exp_value  = v;
        exp_digits = d;
        e.kind = 3'b100; e.val = v; e.dig = d;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] k);
        ev_t e;
        e.kind = k; e.val = exp_value; e.dig = exp_digits;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] c);
        char_in  = c;
        char_vld = 1'b1;
        @(posedge clk);
        #1;
        char_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (value_vld || err_char || err_ovf)) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected event: got %b expected none", {value_vld, err_char, err_ovf});
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("event kind", 64'({value_vld, err_char, err_ovf}), 64'(e.kind));
                check("value", 64'(value), 64'(e.val));
                check("digits", 64'(digits), 64'(e.dig));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset value", 64'(value), 64'd0);
        check("reset digits", 64'(digits), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset pulses", 64'({value_vld, err_char, err_ovf}), 64'd0);

        // basic token, back-to-back strobes
        send_str("1A3F");
        check("busy mid token", 64'(busy), 64'd1);
        push_val(32'h0000_1A3F, 4'd4);
        send(8'h0D);
        check("busy after term", 64'(busy), 64'd0);
        gap();

        // illegal 'x' inside token, flush to space, then a fresh token
        send("0");
        push_err(3'b010);
        send("x");
        send_str("12");
        check("busy in flush", 64'(busy), 64'd1);
        send(8'h20);
        check("busy after flush", 64'(busy), 64'd0);
        check("value held after err", 64'(value), 64'h1A3F);
        send("7");
        push_val(32'h7, 4'd1);
        send(8'h0A);
        gap();

        // overflow on ninth digit
        send_str("12345678");
        push_err(3'b001);
        send("9");
        check("busy after ovf", 64'(busy), 64'd1);
        send(8'h0D);
        check("busy after ovf term", 64'(busy), 64'd0);
        gap();

        // leading and duplicate terminators
        send(8'h20);
        send(8'h20);
        send_str("FF");
        push_val(32'hFF, 4'd2);
        send(8'h0D);
        send(8'h0A);
        gap();

        // exactly WORD_NIBBLES digits, then a digit straight after the terminator
        send_str("DEADBEEF");
        push_val(32'hDEAD_BEEF, 4'd8);
        send(8'h0D);
        send("5");
        push_val(32'h5, 4'd1);
        send(8'h20);
        gap();

        // reset mid token discards partial "AB"
        send_str("AB");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_value  = '0;
        exp_digits = '0;
        check("mid rst value", 64'(value), 64'd0);
        check("mid rst digits", 64'(digits), 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst pulses", 64'({value_vld, err_char, err_ovf}), 64'd0);
        send("C");
        push_val(32'hC, 4'd1);
        send(8'h0D);
        gap();

        // lowercase digits
`ifdef ASCII_HEX_LOWER_EN
        send_str("abc");
        push_val(32'hABC, 4'd3);
        send(8'h0D);
`else
        push_err(3'b010);
        send("a");
        send_str("bc");
        send(8'h0D);
`endif
        gap();

        // illegal in IDLE; further illegal chars in FLUSH stay silent
        push_err(3'b010);
        send("G");
        send_str("Z?");
        send(8'h0A);
        check("value held after idle err", 64'(value), 64'(exp_value));
        gap();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
